// File: rtl/multicycle_control.sv
// Multicycle datapath controller: a Moore FSM that sequences fetch, decode and
// per-opcode execution, with memory wait states driven by mem_ready.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2,
  parameter logic [5:0] OP_ADDI  = 6'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  // state  | meaning
  // FETCH  | read instruction, PC += 4 when memory responds
  // DECODE | read registers, compute branch target, dispatch on opcode
  // MEMADR | compute load/store effective address
  // MEMRD  | load data read, waits on mem_ready
  // MEMWB  | write loaded data to rt
  // MEMWR  | store data write, waits on mem_ready
  // EXEC   | R-type ALU operation
  // ALUWB  | write R-type result to rd
  // BRANCH | compare and conditionally update PC
  // JUMP   | load jump target into PC
  // ADDIEX | add sign-extended immediate
  // ADDIWB | write ADDI result to rt
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic       r_illegal;
  logic       w_legal;

  always_comb begin
    w_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
              (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= 6'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
        if (!w_legal) r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) w_next = S_MEMADR;
        else if (opcode == OP_RTYPE)                w_next = S_EXEC;
        else if (opcode == OP_BEQ)                  w_next = S_BRANCH;
        else if (opcode == OP_J)                    w_next = S_JUMP;
        else if (opcode == OP_ADDI)                 w_next = S_ADDIEX;
        else                                        w_next = S_FETCH;
      end
      S_MEMADR: w_next = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // State-changing strobes are suppressed combinationally while reset is held.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
    end
  end

  assign state      = r_state;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: per-cycle table of inputs and
// expected state/controls, plus hand sequences for reset-in-writeback and wait-state length.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp,instr_done}
  localparam logic [16:0] C_FETCH_R = 17'b1_0_0_1_0_0_1_0_0_0_00_01_00_0;
  localparam logic [16:0] C_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_00_01_00_0;
  localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_00_11_00_0;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_1;
  localparam logic [16:0] C_MEMWR_R = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_1;
  localparam logic [16:0] C_MEMWR_W = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_1_0_0_00_00_10_0;
  localparam logic [16:0] C_ALUWB   = 17'b0_0_0_0_0_0_0_0_1_1_00_00_00_1;
  localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_1_0_0_01_00_01_1;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_10_00_00_1;
  localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_0_1_0_0_00_10_00_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [16:0] ctl_now();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
            RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, instr_done};
  endfunction

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [16:0] c, input logic il);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.st = s; v.ctl = c; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1;

    add(1, 35, 1, 0, C_FETCH_W, 0);
    // LW, no waits
    add(0, 35, 1, 0, C_FETCH_R, 0); add(0, 35, 1, 1, C_DECODE, 0);
    add(0, 35, 1, 2, C_MEMADR, 0);  add(0, 35, 1, 3, C_MEMRD, 0);
    add(0, 35, 1, 4, C_MEMWB, 0);
    // SW with two wait cycles in MEMWR
    add(0, 43, 1, 0, C_FETCH_R, 0); add(0, 43, 1, 1, C_DECODE, 0);
    add(0, 43, 1, 2, C_MEMADR, 0);  add(0, 43, 0, 5, C_MEMWR_W, 0);
    add(0, 43, 0, 5, C_MEMWR_W, 0); add(0, 43, 1, 5, C_MEMWR_R, 0);
    // R-type with one fetch wait
    add(0, 0, 0, 0, C_FETCH_W, 0);  add(0, 0, 1, 0, C_FETCH_R, 0);
    add(0, 0, 1, 1, C_DECODE, 0);   add(0, 0, 1, 6, C_EXEC, 0);
    add(0, 0, 1, 7, C_ALUWB, 0);
    // ADDI
    add(0, 8, 1, 0, C_FETCH_R, 0);  add(0, 8, 1, 1, C_DECODE, 0);
    add(0, 8, 1, 10, C_ADDIEX, 0);  add(0, 8, 1, 11, C_ADDIWB, 0);
    // BEQ, J
    add(0, 4, 1, 0, C_FETCH_R, 0);  add(0, 4, 1, 1, C_DECODE, 0);
    add(0, 4, 1, 8, C_BRANCH, 0);
    add(0, 2, 1, 0, C_FETCH_R, 0);  add(0, 2, 1, 1, C_DECODE, 0);
    add(0, 2, 1, 9, C_JUMP, 0);
    // LW with one MEMRD wait
    add(0, 35, 1, 0, C_FETCH_R, 0); add(0, 35, 1, 1, C_DECODE, 0);
    add(0, 35, 1, 2, C_MEMADR, 0);  add(0, 35, 0, 3, C_MEMRD, 0);
    add(0, 35, 1, 3, C_MEMRD, 0);   add(0, 35, 1, 4, C_MEMWB, 0);
    // illegal opcode, then a J with the flag still set
    add(0, 63, 1, 0, C_FETCH_R, 0); add(0, 63, 1, 1, C_DECODE, 0);
    add(0, 2, 1, 0, C_FETCH_R, 1);  add(0, 2, 1, 1, C_DECODE, 1);
    add(0, 2, 1, 9, C_JUMP, 1);
    // reset during an MEMRD wait
    add(0, 35, 1, 0, C_FETCH_R, 1); add(0, 35, 1, 1, C_DECODE, 1);
    add(0, 35, 1, 2, C_MEMADR, 1);  add(0, 35, 0, 3, C_MEMRD, 1);
    add(1, 35, 0, 3, C_MEMRD, 1);   add(0, 35, 1, 0, C_FETCH_R, 0);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      check($sformatf("v%0d illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
      check($sformatf("v%0d mem_excl", i), 32'((MemRead & MemWrite) | (RegWrite & MemWrite)), 32'(0));
      @(posedge clk); #1;
    end

    // reset asserted in MEMWB: writeback strobes suppressed, then back to FETCH
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0; opcode = 6'd35; mem_ready = 1'b1;
    begin
      int k = 0;
      while (state != 4'd4 && k < 20) begin @(posedge clk); #1; k++; end
      check("reach MEMWB", 32'(state), 32'(4));
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst MEMWB RegWrite", 32'(RegWrite), 32'(0));
    check("rst MEMWB instr_done", 32'(instr_done), 32'(0));
    check("rst MEMWB MemtoReg", 32'(MemtoReg), 32'(1));
    @(posedge clk); #1;
    check("rst MEMWB next state", 32'(state), 32'(0));

    // LW with one FETCH wait and one MEMRD wait takes 7 cycles
    reset = 1'b0; opcode = 6'd35;
    begin
      logic [6:0] mr_pat;
      int done_at = -1;
      int pulses = 0;
      mr_pat = 7'b1101110; // bit c = mem_ready in cycle c
      for (int c = 0; c < 20; c++) begin
        mem_ready = (c < 7) ? mr_pat[c] : 1'b1;
        @(negedge clk);
        if (instr_done) begin
          pulses++;
          if (done_at < 0) done_at = c;
        end
        @(posedge clk); #1;
        if (done_at >= 0) break;
      end
      check("LW 2-wait length", 32'(done_at + 1), 32'(7));
      check("LW 2-wait pulses", 32'(pulses), 32'(1));
      check("LW 2-wait end state", 32'(state), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_RTYPE, 6'd0, R-format opcode.
REQ-002 SHALL have parameter OP_LW, 6'd35, load-word opcode.
REQ-003 SHALL have parameter OP_SW, 6'd43, store-word opcode.
REQ-004 SHALL have parameter OP_BEQ, 6'd4, branch-equal opcode.
REQ-005 SHALL have parameter OP_J, 6'd2, jump opcode.
REQ-006 SHALL have parameter OP_ADDI, 6'd8, add-immediate opcode.
REQ-007 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port opcode, input, 6, IR[31:26]; sampled only in DECODE.
REQ-010 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-011 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each 1 bit, standard multicycle datapath controls.
REQ-012 SHALL have outputs PCSource and ALUSrcB, each 2 bits: PCSource 00 = ALU result, 01 = ALUOut, 10 = jump target; ALUSrcB 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-013 SHALL have output ALUOp, 2, encoding 00 ADD, 01 SUB, 10 R_FORMAT, matching the ALU control block.
REQ-014 SHALL have output state, 4, current FSM state, for debug.
REQ-015 SHALL have output instr_done, 1, one-cycle pulse in the final state of each instruction.
REQ-016 SHALL have output illegal_op, 1, sticky flag set on an unsupported opcode.

Function
REQ-017 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; all outputs decode from the registered state (FETCH also uses mem_ready), and any control not listed for a state SHALL be 0.
REQ-018 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; FSM stays in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDIEX; any other opcode->FETCH with illegal_op set.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD if the opcode latched in DECODE is LW, else MEMWR.
REQ-021 MEMRD: MemRead=1, IorD=1; FSM holds until mem_ready=1, then goes to MEMWB.
REQ-022 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; next state FETCH.
REQ-023 MEMWR: MemWrite=1, IorD=1; FSM holds until mem_ready=1; instr_done=mem_ready; then goes to FETCH.
REQ-024 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-025 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1; next state FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next state FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10, instr_done=1; next state FETCH.
REQ-028 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1; next state FETCH.
REQ-029 With zero wait states, instruction length SHALL be: LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3, J 3; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-030 MemRead and MemWrite SHALL never be asserted in the same cycle, and RegWrite SHALL never be asserted together with MemWrite.
REQ-031 Encodings 12-15 SHALL return to FETCH on the next edge with all controls 0.

Reset
REQ-032 reset=1 at a rising edge SHALL set state=FETCH and clear illegal_op, overriding any pending transition, including mid-instruction or mid-wait.
REQ-033 While reset=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and instr_done SHALL be forced to 0.

Verification
REQ-034 Reset, then opcode=35, mem_ready=1 constantly -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done pulses once.
REQ-035 opcode=43 with mem_ready=0 for 2 cycles in MEMWR -> state sequence 0,1,2,5,5,5,0; MemWrite=1 for 3 cycles; instr_done only in the final cycle of state 5.
REQ-036 opcode=0 -> sequence 0,1,6,7,0; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7. opcode=8 -> sequence 0,1,10,11,0; ALUOp=00 and ALUSrcB=10 in state 10.
REQ-037 opcode=4 -> sequence 0,1,8,0 with ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. opcode=2 -> sequence 0,1,9,0 with PCWrite=1, PCSource=10 in state 9.
REQ-038 opcode=63 -> DECODE goes to FETCH and illegal_op=1 stays set across later instructions; reset asserted during MEMRD with mem_ready=0 -> state=0 and illegal_op=0 on the next edge, with no RegWrite pulse.
